dma_halt_arb: RTL and testbench
===============================

DMA_HALT_ARB -- requirements
Module: dma_halt_arb

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, rising-edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: dma_req  in  1  burst request, sampled only in IDLE.
REQ-004 SHALL have ports: dma_addr  in  16  burst start address, captured with dma_req.
REQ-005 SHALL have ports: dma_len  in  8  burst byte count, captured with dma_req; 0 means 256.
REQ-006 SHALL have ports: dma_busy  out  1  high in every state except IDLE.
REQ-007 SHALL have ports: dma_data  out  8  read byte; dma_valid  out  1  one-cycle strobe qualifying dma_data.
REQ-008 SHALL have ports: dma_done  out  1  one-cycle pulse after the last byte.
REQ-009 SHALL have ports: cpu_ab  in  16, cpu_do  in  8, cpu_rd  in  1 (1 = CPU read cycle).
REQ-010 SHALL have ports: halt_b  out  1  CPU halt, active-low.
REQ-011 SHALL have ports: mem_ab  out  16, mem_do  out  8, mem_we  out  1, mem_di  in  8.
REQ-012 SHALL use reset reset, asynchronous, active-high; clock clk.

Function
REQ-013 SHALL implement FSM states IDLE, HALT_WAIT, SETTLE, BURST, DRAIN, RELEASE.
REQ-014 IDLE: dma_req=1 SHALL capture addr/len and go to HALT_WAIT next edge; halt_b=1.
REQ-015 HALT_WAIT: halt_b=0; SHALL advance to SETTLE on the first edge where cpu_rd=1; pending CPU writes complete unaltered.
REQ-016 SETTLE: SHALL last exactly one cycle, halt_b=0, bus still owned by CPU.
REQ-017 BURST: SHALL drive mem_ab=current address, mem_we=0, one address per cycle; address +1 per cycle, wrapping 0xFFFF->0x0000.
REQ-018 Remaining count SHALL be 9 bits (len 0 loads 256); BURST SHALL exit to DRAIN after issuing the last address.
REQ-019 Memory read latency SHALL be one cycle: dma_data=mem_di with dma_valid=1 in the cycle after each issued address, including the DRAIN cycle.
REQ-020 DRAIN: one cycle delivering the final byte; dma_done SHALL pulse in that same cycle; next state RELEASE.
REQ-021 RELEASE: halt_b=0 one cycle, bus returned to CPU; next state IDLE, where halt_b=1.
REQ-022 Bus mux: in IDLE, HALT_WAIT, SETTLE, RELEASE SHALL drive mem_ab=cpu_ab, mem_do=cpu_do, mem_we=~cpu_rd; in BURST/DRAIN mem_we SHALL be 0.
REQ-023 dma_req outside IDLE SHALL be ignored (no queuing); a held dma_req in IDLE after RELEASE SHALL start a new burst.
REQ-024 Exactly len bytes SHALL be delivered, never an extra dma_valid.

Reset
REQ-025 Reset SHALL force IDLE, halt_b=1, dma_busy=0, dma_valid=0, dma_done=0, dma_data=0, counters/address 0, immediately and asynchronously.
REQ-026 Reset mid-burst SHALL abort without dma_done; bus returns to CPU at once.

Structure
REQ-027 FSM state enum and constant LEN_ZERO_BYTES=256 SHALL live in shared package a78_bus_pkg.
REQ-028 Single module; no sub-modules; burst address/count counter inline.

Verification
REQ-029 dma_req, addr 0x1000, len 3, cpu_rd=1 -> halt_b low 7 cycles (HALT_WAIT..RELEASE); mem_ab 0x1000..0x1002; 3 valid bytes; done with 3rd.
REQ-030 cpu_rd=0 for 3 cycles after request -> mem_we follows CPU for those writes; SETTLE only after cpu_rd=1; no lost write.
REQ-031 addr 0xFFFE, len 4 -> mem_ab 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-032 len 0 -> exactly 256 dma_valid strobes, one dma_done.
REQ-033 reset asserted during 2nd burst cycle -> halt_b=1, dma_busy=0 same cycle; no dma_done; mem_ab=cpu_ab.
REQ-034 dma_req pulsed during BURST -> ignored; held high through RELEASE -> second burst starts from IDLE.

Source files
------------

// File: rtl/a78_bus_pkg.sv
// ---------------------------------------------------------------------------
// a78_bus_pkg
// Shared definitions for the A78 system bus blocks.
//   state_t        : states of the DMA halt arbiter
//   LEN_ZERO_BYTES : byte count meant by a burst length field of zero
//   lenToCount     : turns the 8-bit length field into a 9-bit byte count
// ---------------------------------------------------------------------------
package a78_bus_pkg;

   // The arbiter walks these states in order for every burst: park the CPU,
   // let its last access finish, stream the burst, collect the trailing
   // byte, then hand the bus back.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      HALT_WAIT = 3'd1,
      SETTLE    = 3'd2,
      BURST     = 3'd3,
      DRAIN     = 3'd4,
      RELEASE   = 3'd5
   } state_t;

   // A length field of zero asks for a full 256-byte page.
   localparam int LEN_ZERO_BYTES = 256;

   // The count needs a ninth bit so that 256 can be represented.
   function automatic logic [8:0] lenToCount(input logic [7:0] len);
      logic [8:0] count;
      if (len == 8'd0) begin
         count = 9'(LEN_ZERO_BYTES);
      end else begin
         count = {1'b0, len};
      end
      return count;
   endfunction

endpackage

// File: rtl/dma_halt_arb.sv
// ---------------------------------------------------------------------------
// dma_halt_arb
// Halts the CPU and steals the memory bus to read a burst of bytes.
// Ports:
//   clk, reset              : rising-edge clock, asynchronous active-high reset
//   dma_req/addr/len        : burst request, start address, byte count (0=256)
//   dma_busy                : high whenever the arbiter is not idle
//   dma_data/dma_valid      : read byte and its one-cycle qualifier
//   dma_done                : one-cycle pulse with the final byte
//   cpu_ab/cpu_do/cpu_rd    : CPU address, write data, read/not-write
//   halt_b                  : CPU halt, active-low
//   mem_ab/mem_do/mem_we    : memory address, write data, write enable
//   mem_di                  : memory read data, one cycle after the address
// ---------------------------------------------------------------------------
module dma_halt_arb
   import a78_bus_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        dma_req,
   input  logic [15:0] dma_addr,
   input  logic [7:0]  dma_len,
   output logic        dma_busy,
   output logic [7:0]  dma_data,
   output logic        dma_valid,
   output logic        dma_done,
   input  logic [15:0] cpu_ab,
   input  logic [7:0]  cpu_do,
   input  logic        cpu_rd,
   output logic        halt_b,
   output logic [15:0] mem_ab,
   output logic [7:0]  mem_do,
   output logic        mem_we,
   input  logic [7:0]  mem_di
);

   state_t      state;
   state_t      nextState;
   logic [15:0] burstAddr;
   logic [8:0]  remaining;
   logic        readPending;

   // State register. Reset drops straight back to IDLE so an aborted burst
   // gives the bus back to the CPU without waiting for a clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Burst address and byte counter. They load when a request is accepted
   // in IDLE and step once per issued address; the address wraps naturally
   // at the top of the 16-bit space. readPending remembers that an address
   // went out last cycle, which is exactly when its byte arrives.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         burstAddr   <= 16'h0000;
         remaining   <= 9'd0;
         readPending <= 1'b0;
      end else begin
         readPending <= (state == BURST);
         if ((state == IDLE) && dma_req) begin
            burstAddr <= dma_addr;
            remaining <= lenToCount(dma_len);
         end else if (state == BURST) begin
            burstAddr <= burstAddr + 16'd1;
            remaining <= remaining - 9'd1;
         end
      end
   end

   // Next-state and bus steering. The CPU owns the bus everywhere except
   // BURST and DRAIN; while it is being halted its writes still pass
   // through untouched, and we only move on once it shows a read cycle,
   // since a read can be abandoned safely but a write cannot.
   always_comb begin
      nextState = state;
      halt_b    = 1'b0;
      dma_busy  = 1'b1;
      dma_done  = 1'b0;
      mem_ab    = cpu_ab;
      mem_do    = cpu_do;
      mem_we    = ~cpu_rd;
      case (state)
         IDLE: begin
            halt_b   = 1'b1;
            dma_busy = 1'b0;
            if (dma_req) begin
               nextState = HALT_WAIT;
            end
         end
         HALT_WAIT: begin
            if (cpu_rd) begin
               nextState = SETTLE;
            end
         end
         SETTLE: begin
            nextState = BURST;
         end
         BURST: begin
            mem_ab = burstAddr;
            mem_do = 8'h00;
            mem_we = 1'b0;
            if (remaining == 9'd1) begin
               nextState = DRAIN;
            end
         end
         DRAIN: begin
            mem_ab    = burstAddr;
            mem_do    = 8'h00;
            mem_we    = 1'b0;
            dma_done  = 1'b1;
            nextState = RELEASE;
         end
         RELEASE: begin
            nextState = IDLE;
         end
         default: begin
            halt_b    = 1'b1;
            dma_busy  = 1'b0;
            nextState = IDLE;
         end
      endcase
   end

   // Read data comes straight from memory but is forced to zero whenever
   // it is not qualified, so reset and idle both present a clean zero.
   assign dma_valid = readPending;
   assign dma_data  = readPending ? mem_di : 8'h00;

endmodule

// File: tb/tb_dma_halt_arb.sv
// ---------------------------------------------------------------------------
// tb_dma_halt_arb
// Drives directed and randomised DMA bursts into dma_halt_arb and compares
// every cycle against a burst timeline worked out from the burst
// parameters. The timeline has these phases: CPU-stall phase, one settle
// cycle, len address cycles, one drain cycle, one release cycle.
// ---------------------------------------------------------------------------
module tb_dma_halt_arb;

   logic        clk;
   logic        reset;
   logic        dma_req;
   logic [15:0] dma_addr;
   logic [7:0]  dma_len;
   logic        dma_busy;
   logic [7:0]  dma_data;
   logic        dma_valid;
   logic        dma_done;
   logic [15:0] cpu_ab;
   logic [7:0]  cpu_do;
   logic        cpu_rd;
   logic        halt_b;
   logic [15:0] mem_ab;
   logic [7:0]  mem_do;
   logic        mem_we;
   logic [7:0]  mem_di;

   int total = 0;
   int bad   = 0;

   dma_halt_arb dut (
      .clk       (clk),
      .reset     (reset),
      .dma_req   (dma_req),
      .dma_addr  (dma_addr),
      .dma_len   (dma_len),
      .dma_busy  (dma_busy),
      .dma_data  (dma_data),
      .dma_valid (dma_valid),
      .dma_done  (dma_done),
      .cpu_ab    (cpu_ab),
      .cpu_do    (cpu_do),
      .cpu_rd    (cpu_rd),
      .halt_b    (halt_b),
      .mem_ab    (mem_ab),
      .mem_do    (mem_do),
      .mem_we    (mem_we),
      .mem_di    (mem_di)
   );

   // Free-running 10-time-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents are a fixed scramble of the address so every byte of a
   // burst is distinguishable.
   function automatic logic [7:0] memByte(input logic [15:0] ad);
      return ad[7:0] ^ {ad[11:8], ad[15:12]} ^ 8'hA5;
   endfunction

   // Synchronous memory: the byte for an address appears one cycle later.
   always @(posedge clk) mem_di <= memByte(mem_ab);

   // Single comparison point: counts, asserts, and reports on mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drives one cycle's worth of inputs with random CPU bus activity.
   task automatic applyStimulus(input logic req, input logic rd);
      dma_req = req;
      cpu_rd  = rd;
      cpu_ab  = 16'($urandom);
      cpu_do  = 8'($urandom);
   endtask

   // Outputs expected whenever the arbiter is idle and the CPU runs freely.
   task automatic checkIdle(input string tag);
      logic expWe;
      expWe = ~cpu_rd;
      checkOutput({tag, ".halt_b"},    32'(halt_b),    32'd1);
      checkOutput({tag, ".dma_busy"},  32'(dma_busy),  32'd0);
      checkOutput({tag, ".dma_valid"}, 32'(dma_valid), 32'd0);
      checkOutput({tag, ".dma_done"},  32'(dma_done),  32'd0);
      checkOutput({tag, ".mem_ab"},    32'(mem_ab),    32'(cpu_ab));
      checkOutput({tag, ".mem_do"},    32'(mem_do),    32'(cpu_do));
      checkOutput({tag, ".mem_we"},    32'(mem_we),    32'(expWe));
   endtask

   // Idle cycles with no request; the arbiter must stay put.
   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         applyStimulus(1'b0, 1'($urandom_range(0, 1)));
         @(negedge clk);
         checkIdle("idle");
      end
   endtask

   // One complete burst. w = CPU write cycles before it offers a read,
   // hold keeps dma_req high throughout, pulseK pulses dma_req in that burst
   // cycle, abortK asserts reset in that burst cycle (-1 disables).
   task automatic runBurst(input logic [15:0] a, input logic [7:0] len,
                           input int w, input bit hold, input int pulseK,
                           input int abortK);
      int l, t, k, haltLow, nValid, nDone;
      bit cpuPhase, inBurst;
      logic expWe, req;
      logic [15:0] expAddr;
      l = (len == 8'd0) ? 256 : int'(len);
      t = w + l + 4;
      haltLow = 0;
      nValid  = 0;
      nDone   = 0;

      @(posedge clk); #1;
      applyStimulus(1'b1, 1'($urandom_range(0, 1)));
      dma_addr = a;
      dma_len  = len;
      @(negedge clk);
      checkIdle("accept");

      for (int n = 1; n <= t; n++) begin
         @(posedge clk); #1;
         k       = n - (w + 3);
         inBurst = (n >= w + 3) && (n <= w + 2 + l);
         req     = hold || (inBurst && (k == pulseK));
         if (n <= w) begin
            applyStimulus(req, 1'b0);
         end else if (n == w + 1) begin
            applyStimulus(req, 1'b1);
         end else begin
            applyStimulus(req, 1'($urandom_range(0, 1)));
         end
         dma_addr = 16'($urandom);
         dma_len  = 8'($urandom);

         if (inBurst && (k == abortK)) begin
            reset = 1'b1;
            #1;
            checkOutput("abort.halt_b",    32'(halt_b),    32'd1);
            checkOutput("abort.dma_busy",  32'(dma_busy),  32'd0);
            checkOutput("abort.dma_valid", 32'(dma_valid), 32'd0);
            checkOutput("abort.dma_done",  32'(dma_done),  32'd0);
            checkOutput("abort.dma_data",  32'(dma_data),  32'd0);
            checkOutput("abort.mem_ab",    32'(mem_ab),    32'(cpu_ab));
            checkOutput("abort.doneSeen",  32'(nDone),     32'd0);
            return;
         end

         @(negedge clk);
         if (!halt_b) haltLow++;
         if (dma_valid) nValid++;
         if (dma_done) nDone++;

         cpuPhase = (n <= w + 2) || (n == t);
         expWe    = ~cpu_rd;
         checkOutput("run.halt_b",   32'(halt_b),   32'd0);
         checkOutput("run.dma_busy", 32'(dma_busy), 32'd1);
         if (cpuPhase) begin
            checkOutput("cpu.mem_ab",    32'(mem_ab),    32'(cpu_ab));
            checkOutput("cpu.mem_do",    32'(mem_do),    32'(cpu_do));
            checkOutput("cpu.mem_we",    32'(mem_we),    32'(expWe));
            checkOutput("cpu.dma_valid", 32'(dma_valid), 32'd0);
            checkOutput("cpu.dma_done",  32'(dma_done),  32'd0);
         end else if (inBurst) begin
            expAddr = a + 16'(k);
            checkOutput("burst.mem_ab",    32'(mem_ab),    32'(expAddr));
            checkOutput("burst.mem_we",    32'(mem_we),    32'd0);
            checkOutput("burst.dma_valid", 32'(dma_valid), (k >= 1) ? 32'd1 : 32'd0);
            checkOutput("burst.dma_done",  32'(dma_done),  32'd0);
            if (k >= 1) begin
               checkOutput("burst.dma_data", 32'(dma_data),
                           32'(memByte(a + 16'(k - 1))));
            end
         end else begin
            checkOutput("drain.mem_we",    32'(mem_we),    32'd0);
            checkOutput("drain.dma_valid", 32'(dma_valid), 32'd1);
            checkOutput("drain.dma_done",  32'(dma_done),  32'd1);
            checkOutput("drain.dma_data",  32'(dma_data),
                        32'(memByte(a + 16'(l - 1))));
         end
      end

      checkOutput("burst.haltLowCycles", 32'(haltLow), 32'(w + l + 4));
      checkOutput("burst.validCount",    32'(nValid),  32'(l));
      checkOutput("burst.doneCount",     32'(nDone),   32'd1);
   endtask

   // Directed scenarios first, then a batch of random bursts.
   initial begin
      reset    = 1'b1;
      dma_req  = 1'b0;
      dma_addr = 16'h0000;
      dma_len  = 8'h00;
      cpu_ab   = 16'h1234;
      cpu_do   = 8'h56;
      cpu_rd   = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkIdle("reset");
      checkOutput("reset.dma_data", 32'(dma_data), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      idleCycles(2);

      $display("[TB] basic burst 0x1000 len 3");
      runBurst(16'h1000, 8'd3, 0, 1'b0, -1, -1);
      idleCycles(1);

      $display("[TB] CPU writes pending before halt");
      runBurst(16'($urandom), 8'd5, 3, 1'b0, -1, -1);

      $display("[TB] address wrap");
      runBurst(16'hFFFE, 8'd4, 0, 1'b0, -1, -1);

      $display("[TB] length zero means 256");
      runBurst(16'($urandom), 8'd0, $urandom_range(0, 2), 1'b0, -1, -1);
      idleCycles(1);

      $display("[TB] request pulse during burst is ignored");
      runBurst(16'($urandom), 8'd6, 1, 1'b0, 2, -1);
      idleCycles(3);

      $display("[TB] held request starts a second burst");
      runBurst(16'($urandom), 8'd2, 0, 1'b1, -1, -1);
      runBurst(16'($urandom), 8'd3, 1, 1'b0, -1, -1);
      idleCycles(1);

      $display("[TB] reset in second burst cycle");
      runBurst(16'h2000, 8'd6, 0, 1'b0, -1, 1);
      @(posedge clk); #1;
      reset = 1'b0;
      idleCycles(3);

      $display("[TB] random bursts");
      for (int i = 0; i < 6; i++) begin
         runBurst(16'($urandom), 8'($urandom_range(1, 40)),
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), -1);
         idleCycles($urandom_range(1, 2));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
